prio_code_display: RTL and testbench



---
 rtl/prio_code_display.sv | 144 ++++++++++++++
 tb/tb_prio_code_display.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prio_code_display.sv
// Display stage for the 7-input priority encoder: synchronises and debounces the
// code, latches the last non-zero key, counts key events in BCD and scans a 4-digit display.
module prio_code_display #(
  parameter int STABLE_CYCLES = 1000,
  parameter int SCAN_DIV      = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] D,
  input  logic       ET,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] code,
  output logic [7:0] cnt_bcd
);

  localparam int HW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [HW-1:0] HOLD_MAX = HW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(SCAN_DIV - 1);
  localparam logic [3:0] SYM_DASH  = 4'hA;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:     seg_of = 7'b1000000;
      4'd1:     seg_of = 7'b1111001;
      4'd2:     seg_of = 7'b0100100;
      4'd3:     seg_of = 7'b0110000;
      4'd4:     seg_of = 7'b0011001;
      4'd5:     seg_of = 7'b0010010;
      4'd6:     seg_of = 7'b0000010;
      4'd7:     seg_of = 7'b1111000;
      4'd8:     seg_of = 7'b0000000;
      4'd9:     seg_of = 7'b0010000;
      SYM_DASH: seg_of = 7'b0111111;
      default:  seg_of = 7'b1111111;
    endcase
  endfunction

  logic [3:0]    sync1_reg, sync2_reg;
  logic [2:0]    c, c_prev_reg, q_reg, q_d_reg;
  logic [HW-1:0] hold_reg, hold_next;
  logic          match, accept, event_hit;
  logic [3:0]    ones_next, tens_next;
  logic [DW-1:0] div_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    digit_val;
  logic [3:0]    an_next, an_reg;
  logic [6:0]    seg_reg;

  assign c     = sync2_reg[3] ? sync2_reg[2:0] : 3'd0;
  assign match = (c == c_prev_reg);

  always_comb begin
    hold_next = '0;
    if (match) hold_next = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + 1'b1;
  end

  // Accept on the edge the counter arrives at its ceiling, so q lands STABLE_CYCLES+2 edges after the input.
  assign accept    = (STABLE_CYCLES == 1) || (match && (hold_next == HOLD_MAX));
  assign event_hit = (q_reg != q_d_reg) && (q_reg != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      c_prev_reg <= '0;
      hold_reg   <= '0;
      q_reg      <= '0;
      q_d_reg    <= '0;
    end else begin
      sync1_reg  <= {ET, D};
      sync2_reg  <= sync1_reg;
      c_prev_reg <= c;
      hold_reg   <= hold_next;
      if (accept) q_reg <= c;
      q_d_reg    <= q_reg;
    end
  end

  always_comb begin
    ones_next = cnt_bcd[3:0] + 4'd1;
    tens_next = cnt_bcd[7:4];
    if (cnt_bcd[3:0] == 4'd9) begin
      ones_next = 4'd0;
      tens_next = (cnt_bcd[7:4] == 4'd9) ? 4'd0 : cnt_bcd[7:4] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code    <= '0;
      cnt_bcd <= 8'h00;
    end else if (event_hit) begin
      code    <= q_reg;
      cnt_bcd <= {tens_next, ones_next};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (div_reg == DIV_MAX) begin
      div_reg <= '0;
      idx_reg <= idx_reg + 2'd1;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  always_comb begin
    digit_val = SYM_BLANK;
    case (idx_reg)
      2'd0: digit_val = cnt_bcd[3:0];
      2'd1: digit_val = cnt_bcd[7:4];
      2'd2: digit_val = SYM_BLANK;
      2'd3: digit_val = (code == 3'd0) ? SYM_DASH : {1'b0, code};
      default: digit_val = SYM_BLANK;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_next[gi] = (idx_reg != 2'(gi));
  end

  // Anodes and segments register together so the selected digit never shows a neighbour's pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= 4'b1110;
      seg_reg <= 7'b1000000;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_of(digit_val);
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_prio_code_display.sv
// Bench for prio_code_display with STABLE_CYCLES=4, SCAN_DIV=8: vector table plus
// hand-written latency, reset, scan and BCD-wrap sequences, with an event scoreboard.
module tb_prio_code_display;

  localparam int SC = 4;
  localparam int SD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] D = 3'd0;
  logic       ET = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] code;
  logic [7:0] cnt_bcd;

  prio_code_display #(.STABLE_CYCLES(SC), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .ET(ET), .an(an), .seg(seg), .dp(dp),
    .code(code), .cnt_bcd(cnt_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       et;
    logic [2:0] d;
    int         hold;
    logic       ev;
    logic [2:0] exp_code;
    logic [7:0] exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] cnt;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_digit(input string nm, input logic [3:0] an_t, input logic [6:0] exp);
    int k = 0;
    while (an !== an_t && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk({nm, "_timeout"}, 32'(k), 32'd0);
    else chk(nm, 32'(seg), 32'(exp));
  endtask

  // Scoreboard: every change of code/cnt_bcd must match the next queued expectation.
  initial begin
    logic [2:0] last_code = 3'd0;
    logic [7:0] last_cnt = 8'h00;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_code = 3'd0;
        last_cnt  = 8'h00;
      end else if (code !== last_code || cnt_bcd !== last_cnt) begin
        if (sb.size() == 0) begin
          chk("unexpected_update", {21'd0, code, cnt_bcd}, {21'd0, last_code, last_cnt});
        end else begin
          e = sb.pop_front();
          chk("sb_code", 32'(code), 32'(e.code));
          chk("sb_cnt", 32'(cnt_bcd), 32'(e.cnt));
        end
        last_code = code;
        last_cnt  = cnt_bcd;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [2:0] dv;
    logic [7:0] ec;
    int k;

    vecs[0] = '{1'b1, 3'd3, 3,  1'b0, 3'd5, 8'h01};
    vecs[1] = '{1'b1, 3'd0, 12, 1'b0, 3'd5, 8'h01};
    vecs[2] = '{1'b1, 3'd2, 12, 1'b1, 3'd2, 8'h02};
    vecs[3] = '{1'b1, 3'd0, 12, 1'b0, 3'd2, 8'h02};
    vecs[4] = '{1'b1, 3'd2, 12, 1'b1, 3'd2, 8'h03};
    vecs[5] = '{1'b1, 3'd7, 12, 1'b1, 3'd7, 8'h04};
    vecs[6] = '{1'b0, 3'd6, 50, 1'b0, 3'd7, 8'h04};
    vecs[7] = '{1'b1, 3'd6, 12, 1'b1, 3'd6, 8'h05};
    vecs[8] = '{1'b1, 3'd0, 12, 1'b0, 3'd6, 8'h05};

    // Power-up reset asserted before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_cnt", 32'(cnt_bcd), 32'h00);
    chk("rst_dp", 32'(dp), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_digit("idle_dash", 4'b0111, 7'b0111111);

    // Scan period: each digit stays selected for SD clocks.
    a = an;
    k = 0;
    while (an === a && k < 50) begin @(negedge clk); k++; end
    a = an;
    k = 0;
    while (an === a && k < 50) begin @(negedge clk); k++; end
    chk("scan_period", 32'(k), 32'(SD));

    // Single press with exact latency.
    @(negedge clk);
    ET = 1'b1;
    D  = 3'd5;
    sb.push_back('{3'd5, 8'h01});
    repeat (SC + 2) @(posedge clk);
    @(negedge clk);
    chk("lat_before_code", 32'(code), 32'd0);
    chk("lat_before_cnt", 32'(cnt_bcd), 32'h00);
    @(posedge clk);
    @(negedge clk);
    chk("lat_code", 32'(code), 32'd5);
    chk("lat_cnt", 32'(cnt_bcd), 32'h01);
    repeat (12) @(negedge clk);
    D = 3'd0;
    repeat (12) @(negedge clk);
    $display("press D=5: code=%0d cnt=%02h", code, cnt_bcd);
    chk_digit("d3_five", 4'b0111, 7'b0010010);
    chk_digit("d0_one", 4'b1110, 7'b1111001);
    chk_digit("d1_zero", 4'b1101, 7'b1000000);
    chk_digit("d2_blank", 4'b1011, 7'b1111111);

    for (int i = 0; i < 9; i++) begin
      ET = vecs[i].et;
      D  = vecs[i].d;
      if (vecs[i].ev) sb.push_back('{vecs[i].exp_code, vecs[i].exp_cnt});
      repeat (vecs[i].hold) @(negedge clk);
      $display("vec %0d: ET=%0d D=%0d hold=%0d -> code=%0d cnt=%02h", i, vecs[i].et,
               vecs[i].d, vecs[i].hold, code, cnt_bcd);
      chk($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_bcd), 32'(vecs[i].exp_cnt));
    end

    // Drive the counter through 09 -> 10 and on to 99 -> 00.
    for (int n = 6; n <= 100; n++) begin
      dv = 3'((n % 7) + 1);
      ec = {4'((n / 10) % 10), 4'(n % 10)};
      ET = 1'b1;
      D  = dv;
      sb.push_back('{dv, ec});
      repeat (8) @(negedge clk);
      $display("event %0d: D=%0d -> code=%0d cnt=%02h", n, dv, code, cnt_bcd);
      chk($sformatf("ev%0d_cnt", n), 32'(cnt_bcd), 32'(ec));
      chk($sformatf("ev%0d_code", n), 32'(code), 32'(dv));
      D = 3'd0;
      repeat (8) @(negedge clk);
    end
    chk("wrap_cnt", 32'(cnt_bcd), 32'h00);
    chk_digit("wrap_d1", 4'b1101, 7'b1000000);
    chk_digit("wrap_d0", 4'b1110, 7'b1000000);

    // One more event, then an asynchronous reset mid-operation.
    D = 3'd3;
    sb.push_back('{3'd3, 8'h01});
    repeat (10) @(negedge clk);
    chk("pre_rst_cnt", 32'(cnt_bcd), 32'h01);
    D  = 3'd0;
    ET = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    $display("mid reset: an=%b seg=%b code=%0d cnt=%02h", an, seg, code, cnt_bcd);
    chk("mrst_an", 32'(an), 32'(4'b1110));
    chk("mrst_seg", 32'(seg), 32'(7'b1000000));
    chk("mrst_code", 32'(code), 32'd0);
    chk("mrst_cnt", 32'(cnt_bcd), 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_digit("mrst_dash", 4'b0111, 7'b0111111);
    chk_digit("mrst_d0", 4'b1110, 7'b1000000);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
